uart_recv: RTL and testbench
============================

UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer divide) SHALL be computed at elaboration.
REQ-003 Parameter STAT_ADDR, default 32'h30000010, status register address.
REQ-004 Parameter DATA_ADDR, default 32'h30000014, receive data register address.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-007 rx_pin  input  1  asynchronous serial line, idle high, 8N1 LSB first.
REQ-008 ex_mem_req_i  input  1  bus access request.
REQ-009 ex_mem_we_i  input  1  write enable; writes SHALL be ignored.
REQ-010 ex_mem_raddr_i  input  32  read address.
REQ-011 rd_data_o  output  32  registered read data.
REQ-012 rx_valid_o  output  1  high while FIFO holds at least one byte.
REQ-013 busy_o  output  1  high while receive FSM is not in IDLE.

Function
REQ-014 rx_pin SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized value.
REQ-015 FSM states: IDLE, START, DATA, STOP; a baud counter counts 0..limit, and a bit index counts 0..7.
REQ-016 IDLE: synchronized rx low -> START, with baud counter cleared.
REQ-017 START: after BAUD_DIV/2 cycles sample rx; if low -> DATA with counter cleared; if high (glitch) -> IDLE with no side effects.
REQ-018 DATA: every BAUD_DIV cycles sample rx into shift register bit[index], LSB first; after index 7 -> STOP.
REQ-019 STOP: after BAUD_DIV cycles sample rx; if high push byte into FIFO; if low set frame_err sticky bit and discard byte; both cases -> IDLE.
REQ-020 FIFO: 4 entries x 8 bits, 2-bit read/write pointers wrapping 3->0, 3-bit count 0..4.
REQ-021 Push while count==4: byte discarded, overrun sticky bit set, pointers unchanged.
REQ-022 Read = ex_mem_req_i==1 and ex_mem_we_i==0; rd_data_o updates on the next clock edge (1-cycle latency); it holds its value when there is no read.
REQ-023 Read at DATA_ADDR with count>0: rd_data_o = {24'h0, head byte}; pop the head.
REQ-024 Read at DATA_ADDR with count==0: rd_data_o = 0; no pop; pointers unchanged.
REQ-025 Read at STAT_ADDR: rd_data_o = {26'h0, count[2:0], frame_err, overrun, count!=0}; frame_err and overrun cleared the same edge.
REQ-026 Read at any other address: rd_data_o = 0; no side effects.
REQ-027 Simultaneous push and pop: both performed; count unchanged; push to full FIFO with simultaneous pop SHALL succeed (no overrun).
REQ-028 Simultaneous sticky-bit set and status-read clear: set wins (bit reads 1 next status read).
REQ-029 rx_valid_o = (count!=0); busy_o = (state!=IDLE); both combinational from registered state.

Reset
REQ-030 Reset SHALL force state IDLE, counters 0, pointers 0, count 0, sticky bits 0, rd_data_o 0, synchronizer flops 1.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no FIFO push; after reset deassertion a low rx_pin SHALL be treated as a new start bit.

Verification (bench uses BAUD_DIV=16)
REQ-032 Send 0xA5 8N1, then read DATA_ADDR -> rx_valid_o rises after stop sample; read returns 32'h000000A5; rx_valid_o falls.
REQ-033 Send 5 bytes 0x31..0x35 with no reads, then read STAT_ADDR -> 32'h00000023 (count 4, overrun 1, valid 1); second STAT read -> 32'h00000021; four DATA reads return 0x31..0x34.
REQ-034 Frame 0x55 with stop bit held low -> no push; STAT read -> 32'h00000004; next STAT read -> 0.
REQ-035 4-cycle low glitch on idle rx_pin -> FSM returns IDLE, busy_o low, FIFO count stays 0.
REQ-036 Assert rst during DATA bit 3 of 0x7E, then send 0x42 -> only 0x42 is read from DATA_ADDR; a further DATA read returns 0.
REQ-037 FIFO full, pop read on the same cycle as the stop-bit push -> count stays 4, overrun 0, bytes are read in order.

Source files
------------

// File: rtl/uart_recv.sv
// uart_recv: 8N1 serial receiver with a 4-entry receive FIFO and a
// memory-mapped status/data read port (1-cycle registered read latency).
module uart_recv #(
  parameter int          CLK_FREQ  = 50000000,
  parameter int          BAUD      = 115200,
  parameter logic [31:0] STAT_ADDR = 32'h30000010,
  parameter logic [31:0] DATA_ADDR = 32'h30000014
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_pin,
  input  logic        ex_mem_req_i,
  input  logic        ex_mem_we_i,
  input  logic [31:0] ex_mem_raddr_i,
  output logic [31:0] rd_data_o,
  output logic        rx_valid_o,
  output logic        busy_o
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = $clog2(BAUD_DIV + 1);

  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Receive path state
  // ---------------------------------------------------------------------
  logic             rx_s1, rx_s2;
  logic             rx_sync;
  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [2:0]       idx_q, idx_nxt;
  logic [7:0]       shift_q, shift_nxt;
  logic             push;
  logic             frame_set;

  // ---------------------------------------------------------------------
  // FIFO and bus state
  // ---------------------------------------------------------------------
  logic [7:0]       mem [4];
  logic [1:0]       wptr_q, rptr_q;
  logic [2:0]       count_q;
  logic             frame_err_q, overrun_q;
  logic             rd_en, data_rd, stat_rd;
  logic             pop, push_ok, ovr_set;
  logic             fifo_full, fifo_nonempty;

  assign rx_sync = rx_s2;

  // Two-flop synchronizer on the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would chain rx_s1 straight into rx_s2.
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_pin;
      rx_s2 <= rx_s1;
    end
  end

  // Receive FSM, baud counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      idx_q   <= idx_nxt;
      shift_q <= shift_nxt;
    end
  end

  // Next-state logic: mid-bit sampling, start-glitch rejection, stop check.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    shift_nxt = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_sync) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_nxt = '0;
          if (!rx_sync) begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end else begin
            // Line went back high before mid-start: treat as noise.
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_nxt          = '0;
          shift_nxt[idx_q] = rx_sync;
          if (idx_q == 3'd7) begin
            state_nxt = STOP;
          end else begin
            idx_nxt = idx_q + 1'b1;
          end
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (rx_sync) begin
            push = 1'b1;
          end else begin
            frame_set = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bus decode and FIFO push/pop qualification.
  always_comb begin
    rd_en         = ex_mem_req_i && !ex_mem_we_i;
    data_rd       = rd_en && (ex_mem_raddr_i == DATA_ADDR);
    stat_rd       = rd_en && (ex_mem_raddr_i == STAT_ADDR);
    fifo_full     = (count_q == 3'd4);
    fifo_nonempty = (count_q != 3'd0);
    pop           = data_rd && fifo_nonempty;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    push_ok       = push && (!fifo_full || pop);
    ovr_set       = push && fifo_full && !pop;
  end

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; count_q gates every
    // read of it, so stale contents are never observable.
    if (push_ok) begin
      mem[wptr_q] <= shift_q;
    end
  end

  // FIFO pointers, occupancy count and sticky error bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A new error event on the clearing edge must survive to the next read.
      frame_err_q <= frame_set | (frame_err_q & ~stat_rd);
      overrun_q   <= ovr_set   | (overrun_q   & ~stat_rd);
    end
  end

  // Registered read data; holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_o <= '0;
    end else if (rd_en) begin
      if (data_rd) begin
        rd_data_o <= fifo_nonempty ? {24'h0, mem[rptr_q]} : 32'h0;
      end else if (stat_rd) begin
        rd_data_o <= {26'h0, count_q, frame_err_q, overrun_q, fifo_nonempty};
      end else begin
        rd_data_o <= 32'h0;
      end
    end
  end

  assign rx_valid_o = fifo_nonempty;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Directed self-checking bench for uart_recv at BAUD_DIV = 16.
module tb_uart_recv;

  localparam logic [31:0] STAT_ADDR = 32'h30000010;
  localparam logic [31:0] DATA_ADDR = 32'h30000014;
  localparam int          BIT_CYC   = 16;

  logic        clk;
  logic        rst;
  logic        rx_pin;
  logic        ex_mem_req_i;
  logic        ex_mem_we_i;
  logic [31:0] ex_mem_raddr_i;
  logic [31:0] rd_data_o;
  logic        rx_valid_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic [31:0] dummy;

  uart_recv #(
    .CLK_FREQ (1600),
    .BAUD     (100),
    .STAT_ADDR(STAT_ADDR),
    .DATA_ADDR(DATA_ADDR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_pin        (rx_pin),
    .ex_mem_req_i  (ex_mem_req_i),
    .ex_mem_we_i   (ex_mem_we_i),
    .ex_mem_raddr_i(ex_mem_raddr_i),
    .rd_data_o     (rd_data_o),
    .rx_valid_o    (rx_valid_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at posedge + #1.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    ex_mem_req_i   = 1'b1;
    ex_mem_we_i    = 1'b0;
    ex_mem_raddr_i = addr;
    @(posedge clk);
    #1;
    ex_mem_req_i   = 1'b0;
    data           = rd_data_o;
  endtask

  task automatic bus_write(input logic [31:0] addr);
    ex_mem_req_i   = 1'b1;
    ex_mem_we_i    = 1'b1;
    ex_mem_raddr_i = addr;
    @(posedge clk);
    #1;
    ex_mem_req_i   = 1'b0;
    ex_mem_we_i    = 1'b0;
  endtask

  // Start bit drives edges E0..E15; the receiver samples stop at edge E154
  // (2 sync + 1 detect + 8 half-bit + 9 x 16 bit cycles, counted from E0).
  task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                           input bit chk_valid, input bit pop_stop,
                           output logic [31:0] pop_data);
    pop_data = 32'h0;
    rx_pin = 1'b0;
    idle(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      idle(BIT_CYC);
    end
    rx_pin = stop_bit;
    idle(10);
    if (chk_valid) check("valid_before_stop", {31'h0, rx_valid_o}, 32'h0);
    if (pop_stop) begin
      ex_mem_req_i   = 1'b1;
      ex_mem_we_i    = 1'b0;
      ex_mem_raddr_i = DATA_ADDR;
    end
    @(posedge clk);
    #1;
    ex_mem_req_i = 1'b0;
    if (pop_stop) pop_data = rd_data_o;
    if (chk_valid) check("valid_after_stop", {31'h0, rx_valid_o}, 32'h1);
    idle(5);
    rx_pin = 1'b1;
    idle(12);
  endtask

  initial begin
    rst            = 1'b1;
    rx_pin         = 1'b1;
    ex_mem_req_i   = 1'b0;
    ex_mem_we_i    = 1'b0;
    ex_mem_raddr_i = 32'h0;
    idle(3);
    check("rst_rd_data", rd_data_o, 32'h0);
    check("rst_valid", {31'h0, rx_valid_o}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    rst = 1'b0;
    idle(4);
    bus_read(STAT_ADDR, rd);
    check("rst_status", rd, 32'h0);

    // Single byte 0xA5.
    send_byte(8'hA5, 1'b1, 1'b1, 1'b0, dummy);
    check("a5_busy_idle", {31'h0, busy_o}, 32'h0);
    bus_read(32'h30000018, rd);
    check("other_addr", rd, 32'h0);
    check("other_addr_nopop", {31'h0, rx_valid_o}, 32'h1);
    bus_write(DATA_ADDR);
    bus_read(STAT_ADDR, rd);
    check("write_ignored", rd, 32'h00000009);
    bus_read(DATA_ADDR, rd);
    check("a5_data", rd, 32'h000000A5);
    check("a5_valid_fall", {31'h0, rx_valid_o}, 32'h0);
    idle(3);
    check("rd_hold", rd_data_o, 32'h000000A5);

    // Overrun: five bytes into a four-entry FIFO.
    for (int k = 0; k < 5; k++) send_byte(8'h31 + 8'(k), 1'b1, 1'b0, 1'b0, dummy);
    bus_read(STAT_ADDR, rd);
    check("ovr_stat1", rd, 32'h00000023);
    bus_read(STAT_ADDR, rd);
    check("ovr_stat2", rd, 32'h00000021);
    for (int k = 0; k < 4; k++) begin
      bus_read(DATA_ADDR, rd);
      check("ovr_data", rd, 32'h31 + k);
    end
    bus_read(DATA_ADDR, rd);
    check("empty_data", rd, 32'h0);

    // Framing error: stop bit held low.
    send_byte(8'h55, 1'b0, 1'b0, 1'b0, dummy);
    check("ferr_nopush", {31'h0, rx_valid_o}, 32'h0);
    bus_read(STAT_ADDR, rd);
    check("ferr_stat1", rd, 32'h00000004);
    bus_read(STAT_ADDR, rd);
    check("ferr_stat2", rd, 32'h0);

    // Start-bit glitch: 4 cycles low on an idle line.
    rx_pin = 1'b0;
    idle(4);
    rx_pin = 1'b1;
    idle(2);
    check("glitch_busy_hi", {31'h0, busy_o}, 32'h1);
    idle(20);
    check("glitch_busy_lo", {31'h0, busy_o}, 32'h0);
    check("glitch_valid", {31'h0, rx_valid_o}, 32'h0);
    bus_read(STAT_ADDR, rd);
    check("glitch_stat", rd, 32'h0);

    // Reset during data bit 3 of 0x7E, then a clean 0x42.
    rx_pin = 1'b0;
    idle(BIT_CYC);
    rx_pin = 1'b0; idle(BIT_CYC);
    rx_pin = 1'b1; idle(BIT_CYC);
    rx_pin = 1'b1; idle(BIT_CYC);
    rx_pin = 1'b1; idle(8);
    check("midframe_busy", {31'h0, busy_o}, 32'h1);
    rst    = 1'b1;
    rx_pin = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(4);
    check("abort_busy", {31'h0, busy_o}, 32'h0);
    check("abort_valid", {31'h0, rx_valid_o}, 32'h0);
    send_byte(8'h42, 1'b1, 1'b0, 1'b0, dummy);
    bus_read(DATA_ADDR, rd);
    check("after_rst_data", rd, 32'h00000042);
    bus_read(DATA_ADDR, rd);
    check("after_rst_empty", rd, 32'h0);

    // Full FIFO, pop on the stop-sample edge of a fifth byte.
    for (int k = 0; k < 4; k++) send_byte(8'h31 + 8'(k), 1'b1, 1'b0, 1'b0, dummy);
    send_byte(8'h35, 1'b1, 1'b0, 1'b1, rd);
    check("simul_pop_data", rd, 32'h00000031);
    bus_read(STAT_ADDR, rd);
    check("simul_stat", rd, 32'h00000021);
    for (int k = 0; k < 4; k++) begin
      bus_read(DATA_ADDR, rd);
      check("simul_data", rd, 32'h32 + k);
    end
    check("simul_valid_end", {31'h0, rx_valid_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
